// File: rtl/alu_exec_unit.sv
// EX-stage ALU with a start/ready/done handshake. Shifts run one bit per cycle
// unless ALU_EXEC_BARREL_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CTRL_W  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [CTRL_W-1:0]  i_alucontrol,
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_ready,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_zero,
    output logic               o_invalid
);

    localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_SLLV = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_SRLV = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_SRAV = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] OP_LUI  = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] OP_INV  = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] OP_CMP  = CTRL_W'(15);

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_e;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    typedef enum logic {IDLE, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic               invalid_q, invalid_d;

    logic               is_shift;
    shift_e             kind_sel;
    logic [SHAMT_W-1:0] amt_sel;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_zero;

    // Operation decode and single-cycle datapath, driven straight from the inputs.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_shift = (i_alucontrol <= OP_SRAV);
        kind_sel = SH_LL;
        if (i_alucontrol == OP_SRL || i_alucontrol == OP_SRLV) kind_sel = SH_RL;
        if (i_alucontrol == OP_SRA || i_alucontrol == OP_SRAV) kind_sel = SH_RA;
        amt_sel = (i_alucontrol <= OP_SRA) ? i_shamt : i_a[SHAMT_W-1:0];

        alu_res = '0;
        case (i_alucontrol)
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            OP_SLL, OP_SLLV: alu_res = i_b << amt_sel;
            OP_SRL, OP_SRLV: alu_res = i_b >> amt_sel;
            OP_SRA, OP_SRAV: alu_res = DATA_W'($signed(i_b) >>> amt_sel);
`else
            // Zero-amount shifts finish at accept with the unshifted operand.
            OP_SLL, OP_SLLV, OP_SRL, OP_SRLV, OP_SRA, OP_SRAV: alu_res = i_b;
`endif
            OP_ADD:  alu_res = i_a + i_b;
            OP_SUB:  alu_res = i_a - i_b;
            OP_OR:   alu_res = i_a | i_b;
            OP_XOR:  alu_res = i_a ^ i_b;
            OP_AND:  alu_res = i_a & i_b;
            OP_NOR:  alu_res = ~(i_a | i_b);
            OP_SLT:  alu_res = DATA_W'($signed(i_a) < $signed(i_b));
            OP_LUI:  alu_res = {i_b[15:0], {(DATA_W-16){1'b0}}};
            default: alu_res = '0;
        endcase

        case (i_alucontrol)
            OP_CMP:  alu_zero = (i_a == i_b);
            OP_INV:  alu_zero = 1'b0;
            default: alu_zero = (alu_res == '0);
        endcase
    end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        invalid_d = invalid_q;
        state_d   = IDLE;
        if (i_start) begin
            invalid_d = (i_alucontrol == OP_INV);
            result_d  = alu_res;
            zero_d    = alu_zero;
            state_d   = DONE;
        end
    end

    assign o_ready = 1'b1;
`else
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    shift_e             kind_q, kind_d;
    logic [DATA_W-1:0]  work_step;

    always_comb begin
        case (kind_q)
            SH_RL:   work_step = {1'b0, work_q[DATA_W-1:1]};
            SH_RA:   work_step = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
            default: work_step = {work_q[DATA_W-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        invalid_d = invalid_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        case (state_q)
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = work_step;
                    zero_d   = (work_step == '0);
                    state_d  = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                state_d = IDLE;
                if (i_start) begin
                    invalid_d = (i_alucontrol == OP_INV);
                    if (is_shift && amt_sel != '0) begin
                        work_d  = i_b;
                        cnt_d   = amt_sel;
                        kind_d  = kind_sel;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = alu_zero;
                        state_d  = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            kind_q <= SH_LL;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end

    assign o_ready = (state_q != SHIFT);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            invalid_q <= invalid_d;
        end
    end

    assign o_done    = (state_q == DONE);
    assign o_result  = result_q;
    assign o_zero    = zero_q;
    assign o_invalid = invalid_q;

    // The barrel build never consults the shift-kind decode.
    logic unused_ok;
    assign unused_ok = ^{is_shift, kind_sel};

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (iterative-shift build): handshake,
// latency, opcode results, back-to-back issue and reset during a shift.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        ready, done, zero, invalid;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, busy;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_alucontrol (ctrl),
        .i_a          (a),
        .i_b          (b),
        .i_shamt      (shamt),
        .o_ready      (ready),
        .o_done       (done),
        .o_result     (result),
        .o_zero       (zero),
        .o_invalid    (invalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request (caller sits #1 after a rising edge), then scramble the
    // operands and wait for o_done, returning latency in edges and busy cycles.
    task automatic run_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] sh, output int l, output int bz);
        ctrl  = c;
        a     = av;
        b     = bv;
        shamt = sh;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        shamt = 5'($urandom_range(31));
        ctrl  = 4'($urandom_range(15));
        l  = 1;
        bz = 0;
        while (!done && l < 64) begin
            if (!ready) bz++;
            @(posedge clk);
            #1;
            l++;
        end
        if (!done) check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        ctrl  = 4'd6;
        a     = 32'd1;
        b     = 32'd2;
        shamt = 5'd0;
        #2;
        check("rst_result", result, 32'h0);
        check("rst_done",   {31'b0, done},  32'd0);
        check("rst_ready",  {31'b0, ready}, 32'd1);
        repeat (2) @(posedge clk);
        check("rst_hold_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;

        run_op(4'd6, 32'd5, 32'd7, 5'd0, lat, busy);
        check("add_lat",    lat,    32'd1);
        check("add_result", result, 32'd12);
        check("add_zero",   {31'b0, zero}, 32'd0);

        run_op(4'd7, 32'h1234, 32'h1234, 5'd0, lat, busy);
        check("sub_result", result, 32'h0);
        check("sub_zero",   {31'b0, zero}, 32'd1);

        run_op(4'd12, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, busy);
        check("slt_result", result, 32'd1);

        run_op(4'd13, 32'h0, 32'h0000_ABCD, 5'd0, lat, busy);
        check("lui_result", result, 32'hABCD_0000);

        run_op(4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, busy);
        check("xor_result", result, 32'h0FF0_0FF0);

        run_op(4'd11, 32'h0000_FFFF, 32'hFFFF_0000, 5'd0, lat, busy);
        check("nor_result", result, 32'h0);
        check("nor_zero",   {31'b0, zero}, 32'd1);

        run_op(4'd2, 32'h0, 32'h8000_0000, 5'd4, lat, busy);
        check("sra_lat",    lat,    32'd5);
        check("sra_busy",   busy,   32'd4);
        check("sra_result", result, 32'hF800_0000);

        run_op(4'd4, 32'd31, 32'h8000_0000, 5'd0, lat, busy);
        check("srlv_lat",    lat,    32'd32);
        check("srlv_busy",   busy,   32'd31);
        check("srlv_result", result, 32'd1);

        run_op(4'd3, 32'd8, 32'h0000_0003, 5'd0, lat, busy);
        check("sllv_result", result, 32'h0000_0300);

        // Zero-amount shift, then i_start held so the next op is taken in DONE.
        ctrl  = 4'd0;
        a     = 32'h0;
        b     = 32'h55;
        shamt = 5'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("sll0_done",   {31'b0, done}, 32'd1);
        check("sll0_result", result, 32'h55);
        check("b2b_ready",   {31'b0, ready}, 32'd1);
        ctrl = 4'd8;
        a    = 32'hF0;
        b    = 32'h0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done",   {31'b0, done}, 32'd1);
        check("b2b_result", result, 32'hFF);
        @(posedge clk);
        #1;
        check("b2b_idle", {31'b0, done}, 32'd0);

        run_op(4'd15, 32'd3, 32'd3, 5'd0, lat, busy);
        check("cmp_result", result, 32'h0);
        check("cmp_zero",   {31'b0, zero}, 32'd1);

        run_op(4'd14, 32'd9, 32'd9, 5'd0, lat, busy);
        check("inv_flag",   {31'b0, invalid}, 32'd1);
        check("inv_result", result, 32'h0);
        check("inv_zero",   {31'b0, zero}, 32'd0);

        run_op(4'd15, 32'd3, 32'd4, 5'd0, lat, busy);
        check("cmp_ne_zero",   {31'b0, zero},    32'd0);
        check("inv_clear",     {31'b0, invalid}, 32'd0);

        // Reset during a long shift aborts it with no completion pulse.
        ctrl  = 4'd0;
        b     = 32'h1;
        shamt = 5'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", {31'b0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_done",   {31'b0, done},  32'd0);
        check("mid_rst_ready",  {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        check("mid_no_done", lat, 32'd0);

        run_op(4'd6, 32'hFFFF_FFFF, 32'd2, 5'd0, lat, busy);
        check("post_add_lat",    lat,    32'd1);
        check("post_add_result", result, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, plus the two operands and shamt.
- Performs the selected operation with a start/ready/done handshake.
- Shifts run iteratively, one bit per cycle; all other operations complete in one cycle.
- Sits in the EX stage of the MIPS pipeline; the hazard/stall logic uses o_ready and o_done to freeze the pipeline while a shift is in flight.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).
- CTRL_W, 4, ALU control code width.

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  request; accepted on a rising edge when o_ready=1
- i_alucontrol  in  CTRL_W  operation code
- i_a  in  DATA_W  rs operand
- i_b  in  DATA_W  rt or immediate operand
- i_shamt  in  SHAMT_W  instruction shamt field
- o_ready  out  1  unit can accept i_start this cycle
- o_done  out  1  one-cycle pulse; o_result/o_zero valid
- o_result  out  DATA_W  registered result, held until next accept
- o_zero  out  1  registered zero/equal flag
- o_invalid  out  1  registered; last accepted code was 1110

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE.
  - o_result=0, o_zero=0, o_done=0, o_invalid=0.
  - o_ready=1 during and after reset.
- Code map (A=i_a, B=i_b):
  - 0000 SLL: B<<shamt. 0001 SRL: B>>shamt (logical). 0010 SRA: B>>>shamt (arithmetic).
  - 0011 SLLV, 0100 SRLV, 0101 SRAV: as 0000/0001/0010, but the amount is A[SHAMT_W-1:0].
  - 0110 ADD: A+B, mod 2^DATA_W, no overflow trap.
  - 0111 SUB: A-B. 1000 OR. 1001 XOR. 1010 AND. 1011 NOR.
  - 1100 SLT: signed A<B, giving 1 or 0.
  - 1101 LUI: {B[15:0],16'b0}.
  - 1111 COMPARE/NOP: result=0, o_zero=(A==B). Serves branches, NOP and HALT.
  - 1110: result=0, o_zero=0, o_invalid=1.
- o_zero = (result==0) for every code except 1111 and 1110.
- States: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE) || (state==DONE). Back-to-back issue is allowed.
- Accept edge (i_start && o_ready):
  - Latch code, operands and shift amount N.
  - o_invalid is updated at the accept edge.
  - Non-shift op: o_result/o_zero registered at the accept edge; next state DONE; latency 1.
  - Shift with N=0: result=B, next state DONE; latency 1.
  - Shift with N>0: working reg=B, count=N, next state SHIFT.
- SHIFT:
  - Each edge shifts the working reg by 1 bit (SRA replicates the sign bit) and decrements count.
  - When count goes 1->0, write o_result/o_zero and go to DONE.
  - Latency is N+1 edges after the accept edge; N=31 gives 32.
  - i_start is ignored in SHIFT, since o_ready=0.
- DONE:
  - o_done=1 for exactly one cycle.
  - Next state: IDLE, or accept a new request if i_start=1.
- o_result, o_zero and o_invalid hold their values until the next completion overwrites them.
- Operand inputs may change freely after the accept edge; they are latched.
- Reset mid-SHIFT aborts the operation immediately; no o_done is produced for it.

Optional Feature:
- Macro ALU_EXEC_BARREL_SHIFT_EN.
  - Defined: all shifts use a combinational barrel shifter and complete with latency 1, like other ops. SHIFT state and counter are not instantiated, and o_ready depends only on the IDLE/DONE states.
  - Undefined: iterative 1-bit/cycle shifting as specified above.

Test Plan:
- Reset: i_reset_n=0 with i_start=1 -> o_result=0, o_done=0, o_ready=1. Release, issue ADD A=5, B=7 -> next cycle o_done=1, o_result=12, o_zero=0.
- SUB A=B=0x1234 -> o_result=0, o_zero=1. SLT A=0xFFFFFFFF, B=1 -> o_result=1. LUI B=0xABCD -> o_result=0xABCD0000.
- SRA B=0x80000000, shamt=4 -> o_ready=0 for 4 cycles, o_done on the 5th edge, o_result=0xF8000000. SRLV A=31, B=0x80000000 -> latency 32, o_result=1.
- SLL shamt=0, B=0x55 -> latency 1, o_result=0x55. Back-to-back: i_start held through DONE with OR 0xF0|0x0F -> accepted in DONE, o_result=0xFF on the next o_done.
- Code 1111 A=3, B=3 -> o_zero=1, o_result=0. Code 1110 -> o_invalid=1, o_result=0.
- Reset asserted mid-SHIFT (SLL shamt=20, reset after 5 cycles) -> outputs 0 immediately, no o_done. After release, o_ready=1 and a new ADD completes normally.
